// File: rtl/sc_fibo_pkg.sv
// Shared constants for the Fibonacci sequencer: default data width and FSM state encoding.
package sc_fibo_pkg;

   localparam int FIBO_DATAWIDTH = 8;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CLEAR = 3'd1;
   localparam logic [2:0] ST_INIT  = 3'd2;
   localparam logic [2:0] ST_STEP  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/SC_RegGENERAL.sv
// General-purpose register with active-low clear (priority) and load strobes.
module SC_RegGENERAL #(
   parameter int DATAWIDTH = 8
) (
   input  logic                 SC_RegGENERAL_CLOCK_50,
   input  logic                 SC_RegGENERAL_RESET_InHigh,
   input  logic                 SC_RegGENERAL_clear_InLow,
   input  logic                 SC_RegGENERAL_load_InLow,
   input  logic [DATAWIDTH-1:0] SC_RegGENERAL_data_InBUS,
   output logic [DATAWIDTH-1:0] SC_RegGENERAL_data_OutBUS
);

   logic [DATAWIDTH-1:0] r_data;

   always_ff @(posedge SC_RegGENERAL_CLOCK_50, posedge SC_RegGENERAL_RESET_InHigh) begin
      if (SC_RegGENERAL_RESET_InHigh)
         r_data <= '0;
      else if (!SC_RegGENERAL_clear_InLow)
         r_data <= '0;
      else if (!SC_RegGENERAL_load_InLow)
         r_data <= SC_RegGENERAL_data_InBUS;
   end

   assign SC_RegGENERAL_data_OutBUS = r_data;

endmodule

// File: rtl/sc_fibo_adder.sv
// Width-parameterised unsigned adder exposing the carry out for overflow detection.
module sc_fibo_adder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry
);

   assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/sc_fibo_sequencer.sv
// Drives two external registers through clear/init/step strobes so that A=F(n), B=F(n+1).
//  state | meaning
//  IDLE  | waiting for start_InLow low; latches nterms on accept
//  CLEAR | both clear strobes low
//  INIT  | B <= 1
//  STEP  | A <= B, B <= A+B; stops at nterms steps or on carry
//  DONE  | one-cycle done pulse, back to IDLE
module sc_fibo_sequencer
   import sc_fibo_pkg::*;
#(
   parameter int DATAWIDTH = FIBO_DATAWIDTH
) (
   input  logic                 SC_RegGENERAL_CLOCK_50,
   input  logic                 SC_RegGENERAL_RESET_InHigh,
   input  logic                 start_InLow,
   input  logic [7:0]           nterms_InBUS,
   input  logic [DATAWIDTH-1:0] regA_data_InBUS,
   input  logic [DATAWIDTH-1:0] regB_data_InBUS,
   output logic                 regA_clear_OutLow,
   output logic                 regA_load_OutLow,
   output logic                 regB_clear_OutLow,
   output logic                 regB_load_OutLow,
   output logic [DATAWIDTH-1:0] regA_data_OutBUS,
   output logic [DATAWIDTH-1:0] regB_data_OutBUS,
   output logic                 busy_OutHigh,
   output logic                 done_OutHigh,
   output logic                 overflow_OutHigh
);

   logic [2:0]           r_state;
   logic [2:0]           w_state_next;
   logic [7:0]           r_nterms;
   logic [7:0]           r_count;
   logic [7:0]           w_count_inc;
   logic                 r_overflow;
   logic [DATAWIDTH-1:0] w_sum;
   logic                 w_carry;

   sc_fibo_adder #(.WIDTH(DATAWIDTH)) u_adder (
      .i_a     (regA_data_InBUS),
      .i_b     (regB_data_InBUS),
      .o_sum   (w_sum),
      .o_carry (w_carry)
   );

   assign w_count_inc = r_count + 8'd1;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (!start_InLow) w_state_next = ST_CLEAR;
         ST_CLEAR: w_state_next = ST_INIT;
         ST_INIT:  w_state_next = (r_nterms == 8'd0) ? ST_DONE : ST_STEP;
         ST_STEP:  if (w_carry || (w_count_inc == r_nterms)) w_state_next = ST_DONE;
         ST_DONE:  w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge SC_RegGENERAL_CLOCK_50, posedge SC_RegGENERAL_RESET_InHigh) begin
      if (SC_RegGENERAL_RESET_InHigh) begin
         r_state    <= ST_IDLE;
         r_nterms   <= 8'd0;
         r_count    <= 8'd0;
         r_overflow <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if ((r_state == ST_IDLE) && !start_InLow) begin
            r_nterms   <= nterms_InBUS;
            r_count    <= 8'd0;
            r_overflow <= 1'b0;
         end else if (r_state == ST_STEP) begin
            if (w_carry)
               r_overflow <= 1'b1;
            else
               r_count <= w_count_inc;
         end
      end
   end

   // Strobes and load data are decoded straight from state so loads land on the same edge.
   always_comb begin
      regA_clear_OutLow = 1'b1;
      regB_clear_OutLow = 1'b1;
      regA_load_OutLow  = 1'b1;
      regB_load_OutLow  = 1'b1;
      regA_data_OutBUS  = '0;
      regB_data_OutBUS  = '0;
      case (r_state)
         ST_CLEAR: begin
            regA_clear_OutLow = 1'b0;
            regB_clear_OutLow = 1'b0;
         end
         ST_INIT: begin
            regB_load_OutLow = 1'b0;
            regB_data_OutBUS = DATAWIDTH'(1);
         end
         ST_STEP: begin
            regA_data_OutBUS = regB_data_InBUS;
            regB_data_OutBUS = w_sum;
            if (!w_carry) begin
               regA_load_OutLow = 1'b0;
               regB_load_OutLow = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign busy_OutHigh     = (r_state == ST_CLEAR) || (r_state == ST_INIT) || (r_state == ST_STEP);
   assign done_OutHigh     = (r_state == ST_DONE);
   assign overflow_OutHigh = r_overflow;

endmodule

// File: tb/tb_sc_fibo_sequencer.sv
// Closed-loop bench: sequencer driving two SC_RegGENERAL registers, results scored against a Fibonacci model.
module tb_sc_fibo_sequencer;
   import sc_fibo_pkg::*;

   localparam int W = FIBO_DATAWIDTH;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ovf;
      int           done_cycle;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start_InLow = 1'b1;
   logic [7:0]   nterms_InBUS = 8'd0;
   logic [W-1:0] w_a, w_b;
   logic         a_clr, a_ld, b_clr, b_ld;
   logic [W-1:0] a_dout, b_dout;
   logic         busy, done, ovf;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #10 clk = ~clk;

   sc_fibo_sequencer #(.DATAWIDTH(W)) dut (
      .SC_RegGENERAL_CLOCK_50     (clk),
      .SC_RegGENERAL_RESET_InHigh (rst),
      .start_InLow                (start_InLow),
      .nterms_InBUS               (nterms_InBUS),
      .regA_data_InBUS            (w_a),
      .regB_data_InBUS            (w_b),
      .regA_clear_OutLow          (a_clr),
      .regA_load_OutLow           (a_ld),
      .regB_clear_OutLow          (b_clr),
      .regB_load_OutLow           (b_ld),
      .regA_data_OutBUS           (a_dout),
      .regB_data_OutBUS           (b_dout),
      .busy_OutHigh               (busy),
      .done_OutHigh               (done),
      .overflow_OutHigh           (ovf)
   );

   SC_RegGENERAL #(.DATAWIDTH(W)) u_reg_a (
      .SC_RegGENERAL_CLOCK_50     (clk),
      .SC_RegGENERAL_RESET_InHigh (rst),
      .SC_RegGENERAL_clear_InLow  (a_clr),
      .SC_RegGENERAL_load_InLow   (a_ld),
      .SC_RegGENERAL_data_InBUS   (a_dout),
      .SC_RegGENERAL_data_OutBUS  (w_a)
   );

   SC_RegGENERAL #(.DATAWIDTH(W)) u_reg_b (
      .SC_RegGENERAL_CLOCK_50     (clk),
      .SC_RegGENERAL_RESET_InHigh (rst),
      .SC_RegGENERAL_clear_InLow  (b_clr),
      .SC_RegGENERAL_load_InLow   (b_ld),
      .SC_RegGENERAL_data_InBUS   (b_dout),
      .SC_RegGENERAL_data_OutBUS  (w_b)
   );

   function automatic exp_t model(input int n);
      exp_t         e;
      logic [W:0]   s;
      logic [W-1:0] a, b;
      a = '0;
      b = W'(1);
      e.ovf = 1'b0;
      e.done_cycle = 3 + n;
      for (int i = 0; i < n; i++) begin
         s = {1'b0, a} + {1'b0, b};
         if (s[W]) begin
            e.ovf = 1'b1;
            e.done_cycle = 4 + i;
            break;
         end
         a = b;
         b = s[W-1:0];
      end
      e.a = a;
      e.b = b;
      return e;
   endfunction

   // Leaves the bench at the falling edge of cycle 1 (CLEAR) with start released.
   task automatic do_start(input int n);
      exp_q.push_back(model(n));
      start_InLow  = 1'b0;
      nterms_InBUS = n[7:0];
      @(negedge clk);
      start_InLow = 1'b1;
   endtask

   // Bounded wait; cyc stays 0 if done never shows up.
   task automatic wait_done(input int from_cycle, output int cyc);
      cyc = 0;
      for (int c = from_cycle; c < from_cycle + 400; c++) begin
         if (done === 1'b1) begin
            cyc = c;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      n_vec++; if ({a_clr, b_clr, a_ld, b_ld} !== 4'b1111) begin n_err++; $display("FAIL reset_strobes got %b want 1111", {a_clr, b_clr, a_ld, b_ld}); end
      n_vec++; if ({busy, done, ovf} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {busy, done, ovf}); end
      n_vec++; if ({a_dout, b_dout} !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", {a_dout, b_dout}); end
   endtask

   task automatic test_nterms0();
      exp_t e;
      int   cyc;
      do_start(0);
      n_vec++; if ({a_clr, b_clr, a_ld, b_ld, busy} !== 5'b00111) begin n_err++; $display("FAIL clear_cycle got %b want 00111", {a_clr, b_clr, a_ld, b_ld, busy}); end
      @(negedge clk);
      n_vec++; if ({a_clr, b_clr, a_ld, b_ld, busy} !== 5'b11101) begin n_err++; $display("FAIL init_cycle got %b want 11101", {a_clr, b_clr, a_ld, b_ld, busy}); end
      n_vec++; if (b_dout !== W'(1)) begin n_err++; $display("FAIL init_data got %0d want 1", b_dout); end
      @(negedge clk);
      wait_done(3, cyc);
      e = exp_q.pop_front();
      n_vec++; if (cyc !== e.done_cycle) begin n_err++; $display("FAIL n0_done_cycle got %0d want %0d", cyc, e.done_cycle); end
      n_vec++; if ({w_a, w_b, ovf} !== {e.a, e.b, e.ovf}) begin n_err++; $display("FAIL n0_result got A=%0d B=%0d ovf=%b want A=%0d B=%0d ovf=%b", w_a, w_b, ovf, e.a, e.b, e.ovf); end
      @(negedge clk);
      n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL done_pulse_width got %b want 00", {busy, done}); end
   endtask

   task automatic test_run(input int n);
      exp_t e;
      int   cyc;
      do_start(n);
      wait_done(1, cyc);
      e = exp_q.pop_front();
      n_vec++; if (cyc !== e.done_cycle) begin n_err++; $display("FAIL n%0d_done_cycle got %0d want %0d", n, cyc, e.done_cycle); end
      n_vec++; if ({w_a, w_b, ovf} !== {e.a, e.b, e.ovf}) begin n_err++; $display("FAIL n%0d_result got A=%0d B=%0d ovf=%b want A=%0d B=%0d ovf=%b", n, w_a, w_b, ovf, e.a, e.b, e.ovf); end
      @(negedge clk);
   endtask

   task automatic test_overflow();
      test_run(12);
      test_run(20);
      repeat (2) @(negedge clk);
      n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", ovf); end
      do_start(1);
      n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear_on_start got %b want 0", ovf); end
      begin
         exp_t e;
         int   cyc;
         wait_done(1, cyc);
         e = exp_q.pop_front();
         n_vec++; if ({cyc, w_a, w_b, ovf} !== {e.done_cycle, e.a, e.b, e.ovf}) begin n_err++; $display("FAIL n1_run got cyc=%0d A=%0d B=%0d ovf=%b want cyc=%0d A=%0d B=%0d ovf=%b", cyc, w_a, w_b, ovf, e.done_cycle, e.a, e.b, e.ovf); end
         @(negedge clk);
      end
   endtask

   task automatic test_start_during_step();
      exp_t e;
      int   cyc;
      do_start(10);
      repeat (5) @(negedge clk);
      start_InLow = 1'b0;
      @(negedge clk);
      start_InLow = 1'b1;
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_during_step got %b want 1", busy); end
      wait_done(7, cyc);
      e = exp_q.pop_front();
      n_vec++; if ({cyc, w_a, w_b, ovf} !== {e.done_cycle, e.a, e.b, e.ovf}) begin n_err++; $display("FAIL start_ignored got cyc=%0d A=%0d B=%0d ovf=%b want cyc=%0d A=%0d B=%0d ovf=%b", cyc, w_a, w_b, ovf, e.done_cycle, e.a, e.b, e.ovf); end
      @(negedge clk);
      @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL no_retrigger got busy=%b want 0", busy); end
   endtask

   task automatic test_reset_mid_run();
      do_start(10);
      repeat (6) @(negedge clk);
      void'(exp_q.pop_front());
      rst = 1'b1;
      #1;
      n_vec++; if ({a_clr, b_clr, a_ld, b_ld, busy, done} !== 6'b111100) begin n_err++; $display("FAIL abort_outputs got %b want 111100", {a_clr, b_clr, a_ld, b_ld, busy, done}); end
      n_vec++; if ({w_a, w_b} !== '0) begin n_err++; $display("FAIL abort_regs got A=%0d B=%0d want 0 0", w_a, w_b); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_vec++; if ({busy, a_clr, b_clr, a_ld, b_ld} !== 5'b01111) begin n_err++; $display("FAIL post_abort_idle got %b want 01111", {busy, a_clr, b_clr, a_ld, b_ld}); end
      test_run(10);
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   cyc;
      exp_q.push_back(model(3));
      exp_q.push_back(model(3));
      start_InLow  = 1'b0;
      nterms_InBUS = 8'd3;
      @(negedge clk);
      wait_done(1, cyc);
      e = exp_q.pop_front();
      n_vec++; if ({cyc, w_a, w_b, ovf} !== {e.done_cycle, e.a, e.b, e.ovf}) begin n_err++; $display("FAIL b2b_first got cyc=%0d A=%0d B=%0d want cyc=%0d A=%0d B=%0d", cyc, w_a, w_b, e.done_cycle, e.a, e.b); end
      @(negedge clk);
      n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL b2b_idle_gap got %b want 00", {busy, done}); end
      @(negedge clk);
      start_InLow = 1'b1;
      n_vec++; if ({a_clr, b_clr, a_ld, b_ld, busy} !== 5'b00111) begin n_err++; $display("FAIL b2b_retrigger got %b want 00111", {a_clr, b_clr, a_ld, b_ld, busy}); end
      wait_done(1, cyc);
      e = exp_q.pop_front();
      n_vec++; if ({cyc, w_a, w_b, ovf} !== {e.done_cycle, e.a, e.b, e.ovf}) begin n_err++; $display("FAIL b2b_second got cyc=%0d A=%0d B=%0d want cyc=%0d A=%0d B=%0d", cyc, w_a, w_b, e.done_cycle, e.a, e.b); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_nterms0();
      test_run(10);
      test_overflow();
      test_start_during_step();
      test_reset_mid_run();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
